// File: rtl/axil_simp_pkg.sv
// Shared types and constants for the simple-driver to AXI4-Lite master engine.
package axil_simp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // States in which the engine is waiting on the AXI slave.
  function automatic logic is_busy(state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/axil_simp_wdog.sv
// Stall watchdog: counts cycles spent in a busy state, cleared on every state change.
module axil_simp_wdog
  import axil_simp_pkg::*;
#(
  parameter int C_TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic restart,
  output logic expire
);

  localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || !active) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires on the cycle whose edge would be the C_TIMEOUT_CYCLES-th in this state.
  assign expire = active && (cnt_q == LIMIT);

endmodule

// File: rtl/axil_simp_master.sv
// Single-outstanding AXI4-Lite master driven by a level exec / four-phase fin command port.
// Optional stall watchdog enabled with `define AXIL_SIMP_TIMEOUT_EN.
module axil_simp_master
  import axil_simp_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int C_AXI_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int C_TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   si_address,
  input  logic [C_AXI_DATA_WIDTH-1:0]   si_data,
  input  logic                          we,
  input  logic                          exec,
  output logic                          fin,
  output logic [C_AXI_DATA_WIDTH-1:0]   so_data,
  output logic [1:0]                    so_resp,
  output logic [C_AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]                    awprot,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]                    arprot,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  output logic                          rready
);

  state_t                        state_q, state_d;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                          awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                          arvalid_q, arvalid_d, bready_q, bready_d;
  logic                          rready_q, rready_d, fin_q, fin_d;
  logic [C_AXI_DATA_WIDTH-1:0]   so_data_q, so_data_d;
  logic [1:0]                    so_resp_q, so_resp_d;

`ifdef AXIL_SIMP_TIMEOUT_EN
  logic wdog_expire;
  logic wdog_restart;

  assign wdog_restart = (state_d != state_q);

  axil_simp_wdog #(.C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .active  (is_busy(state_q)),
    .restart (wdog_restart),
    .expire  (wdog_expire)
  );
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    fin_d     = fin_q;
    so_data_d = so_data_q;
    so_resp_d = so_resp_q;
    case (state_q)
      IDLE: begin
        if (exec) begin
          addr_d  = si_address;
          wdata_d = si_data;
          if (we) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; move on once neither is pending.
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d  = 1'b0;
          so_resp_d = bresp;
          fin_d     = 1'b1;
          state_d   = DONE;
        end
      end
      RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          rready_d  = 1'b0;
          so_data_d = rdata;
          so_resp_d = rresp;
          fin_d     = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (!exec) begin
          fin_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXIL_SIMP_TIMEOUT_EN
    // Abandon the stalled transaction and report it as a slave error.
    if (wdog_expire) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      bready_d  = 1'b0;
      rready_d  = 1'b0;
      so_resp_d = RESP_SLVERR;
      fin_d     = 1'b1;
      state_d   = DONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      fin_q     <= 1'b0;
      so_data_q <= '0;
      so_resp_q <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      fin_q     <= fin_d;
      so_data_q <= so_data_d;
      so_resp_q <= so_resp_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign fin     = fin_q;
  assign so_data = so_data_q;
  assign so_resp = so_resp_q;
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = wdata_q;
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign arvalid = arvalid_q;
  assign bready  = bready_q;
  assign rready  = rready_q;
  assign wstrb   = '1;
  assign awprot  = 3'b000;
  assign arprot  = 3'b000;

endmodule
